// File: rtl/fighter_pkg.sv
// Shared types and default timing for the fighter action sequencer.
package fighter_pkg;

  typedef enum logic [2:0] {
    A_IDLE     = 3'd0,
    A_WALK_L   = 3'd1,
    A_WALK_R   = 3'd2,
    A_ATTACK   = 3'd3,
    A_DEFEND   = 3'd4,
    A_COOLDOWN = 3'd5
  } action_t;

  typedef enum logic [1:0] {
    PH_TITLE = 2'd0,
    PH_PLAY  = 2'd1,
    PH_OVER  = 2'd2
  } phase_t;

  localparam int unsigned ATK_FRAMES_DEF    = 6;
  localparam int unsigned ATK_HIT_FRAME_DEF = 3;
  localparam int unsigned COOL_FRAMES_DEF   = 4;
  localparam int unsigned WALK_LEN_DEF      = 8;
  localparam int unsigned ANIM_W_DEF        = 4;

  // Defense beats a fresh attack, which beats a single move key.
  function automatic action_t pick_action(
    input logic l,
    input logic r,
    input logic atk_edge,
    input logic def
  );
    action_t a;
    a = A_IDLE;
    if (def)
      a = A_DEFEND;
    else if (atk_edge)
      a = A_ATTACK;
    else if (l && !r)
      a = A_WALK_L;
    else if (r && !l)
      a = A_WALK_R;
    return a;
  endfunction

endpackage

// File: rtl/player_action_fsm.sv
// Per-player action state machine, stepped on frame_tick.
module player_action_fsm
  import fighter_pkg::*;
#(
  parameter int unsigned ATK_FRAMES    = ATK_FRAMES_DEF,
  parameter int unsigned ATK_HIT_FRAME = ATK_HIT_FRAME_DEF,
  parameter int unsigned COOL_FRAMES   = COOL_FRAMES_DEF,
  parameter int unsigned WALK_LEN      = WALK_LEN_DEF,
  parameter int unsigned ANIM_W        = ANIM_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              force_idle,
  input  logic              move_l,
  input  logic              move_r,
  input  logic              attack,
  input  logic              defense,
  output logic [2:0]        action,
  output logic [ANIM_W-1:0] anim,
  output logic              strike
);

  localparam logic [ANIM_W-1:0] ATK_LAST  = ANIM_W'(ATK_FRAMES - 1);
  localparam logic [ANIM_W-1:0] HIT_IDX   = ANIM_W'(ATK_HIT_FRAME);
  localparam logic [ANIM_W-1:0] COOL_LAST = ANIM_W'(COOL_FRAMES - 1);
  localparam logic [ANIM_W-1:0] WALK_LAST = ANIM_W'(WALK_LEN - 1);
  localparam logic [ANIM_W-1:0] ONE       = ANIM_W'(1);

  action_t           act_q, act_d;
  logic [ANIM_W-1:0] anim_q, anim_d;
  logic              strike_q, strike_d;
  logic              atk_prev_q, atk_prev_d;
  logic              atk_edge;
  action_t           pick;

  always_comb begin
    atk_edge   = attack & ~atk_prev_q;
    pick       = pick_action(move_l, move_r, atk_edge, defense);
    act_d      = act_q;
    anim_d     = anim_q;
    strike_d   = 1'b0;
    atk_prev_d = atk_prev_q;
    if (frame_tick) begin
      atk_prev_d = attack;
      unique case (act_q)
        A_ATTACK:
          act_d = (anim_q == ATK_LAST) ? A_COOLDOWN : A_ATTACK;
        A_COOLDOWN:
          act_d = (anim_q == COOL_LAST) ? pick : A_COOLDOWN;
        default:
          act_d = pick;
      endcase
      if (act_d != act_q) begin
        anim_d = '0;
      end else begin
        unique case (act_q)
          A_WALK_L, A_WALK_R:
            anim_d = (anim_q == WALK_LAST) ? '0 : anim_q + ONE;
          A_ATTACK, A_COOLDOWN:
            anim_d = anim_q + ONE;
          default:
            anim_d = '0;
        endcase
      end
      strike_d = (act_d == A_ATTACK) && (anim_d == HIT_IDX);
    end
    // Aborts any attack; key history keeps tracking so held keys stay held.
    if (force_idle) begin
      act_d    = A_IDLE;
      anim_d   = '0;
      strike_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      act_q      <= A_IDLE;
      anim_q     <= '0;
      strike_q   <= 1'b0;
      atk_prev_q <= 1'b1;
    end else begin
      act_q      <= act_d;
      anim_q     <= anim_d;
      strike_q   <= strike_d;
      atk_prev_q <= atk_prev_d;
    end
  end

  assign action = act_q;
  assign anim   = anim_q;
  assign strike = strike_q;

endmodule

// File: rtl/fighter_action_sequencer.sv
// Game-phase FSM plus two independent player action FSMs.
module fighter_action_sequencer
  import fighter_pkg::*;
#(
  parameter int unsigned ATK_FRAMES    = ATK_FRAMES_DEF,
  parameter int unsigned ATK_HIT_FRAME = ATK_HIT_FRAME_DEF,
  parameter int unsigned COOL_FRAMES   = COOL_FRAMES_DEF,
  parameter int unsigned WALK_LEN      = WALK_LEN_DEF,
  parameter int unsigned ANIM_W        = ANIM_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              p1_move_l,
  input  logic              p1_move_r,
  input  logic              p1_attack,
  input  logic              p1_defense,
  input  logic              p2_move_l,
  input  logic              p2_move_r,
  input  logic              p2_attack,
  input  logic              p2_defense,
  input  logic              start_key,
  input  logic              game_over,
  output logic [1:0]        phase,
  output logic              round_reset,
  output logic [2:0]        p1_action,
  output logic [2:0]        p2_action,
  output logic [ANIM_W-1:0] p1_anim,
  output logic [ANIM_W-1:0] p2_anim,
  output logic              p1_strike,
  output logic              p2_strike
);

  phase_t phase_q, phase_d;
  logic   rr_q, rr_d;
  logic   start_q, start_d;
  logic   start_edge;
  logic   force_idle;

  always_comb begin
    start_d    = start_key;
    start_edge = start_key & ~start_q;
    phase_d    = phase_q;
    unique case (phase_q)
      PH_TITLE: if (start_edge) phase_d = PH_PLAY;
      PH_PLAY:  if (game_over)  phase_d = PH_OVER;
      PH_OVER:  if (start_edge) phase_d = PH_PLAY;
      default:  phase_d = PH_TITLE;
    endcase
    rr_d = (phase_d == PH_PLAY) && (phase_q != PH_PLAY);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      phase_q <= PH_TITLE;
      rr_q    <= 1'b0;
      start_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      rr_q    <= rr_d;
      start_q <= start_d;
    end
  end

  assign force_idle  = (phase_q != PH_PLAY) | rr_q;
  assign phase       = phase_q;
  assign round_reset = rr_q;

  player_action_fsm #(
    .ATK_FRAMES   (ATK_FRAMES),
    .ATK_HIT_FRAME(ATK_HIT_FRAME),
    .COOL_FRAMES  (COOL_FRAMES),
    .WALK_LEN     (WALK_LEN),
    .ANIM_W       (ANIM_W)
  ) u_p1 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .force_idle(force_idle),
    .move_l    (p1_move_l),
    .move_r    (p1_move_r),
    .attack    (p1_attack),
    .defense   (p1_defense),
    .action    (p1_action),
    .anim      (p1_anim),
    .strike    (p1_strike)
  );

  player_action_fsm #(
    .ATK_FRAMES   (ATK_FRAMES),
    .ATK_HIT_FRAME(ATK_HIT_FRAME),
    .COOL_FRAMES  (COOL_FRAMES),
    .WALK_LEN     (WALK_LEN),
    .ANIM_W       (ANIM_W)
  ) u_p2 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .force_idle(force_idle),
    .move_l    (p2_move_l),
    .move_r    (p2_move_r),
    .attack    (p2_attack),
    .defense   (p2_defense),
    .action    (p2_action),
    .anim      (p2_anim),
    .strike    (p2_strike)
  );

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Bench for fighter_action_sequencer: table, directed sequences, random vs model.
module tb_fighter_action_sequencer;

  localparam int ATK  = 6;
  localparam int HIT  = 3;
  localparam int COOL = 4;
  localparam int WALK = 8;
  localparam int AW   = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset_n, frame_tick, start_key, game_over;
  logic p1_l, p1_r, p1_a, p1_d;
  logic p2_l, p2_r, p2_a, p2_d;
  logic [1:0]    phase;
  logic          round_reset;
  logic [2:0]    p1_action, p2_action;
  logic [AW-1:0] p1_anim, p2_anim;
  logic          p1_strike, p2_strike;

  fighter_action_sequencer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .p1_move_l  (p1_l),
    .p1_move_r  (p1_r),
    .p1_attack  (p1_a),
    .p1_defense (p1_d),
    .p2_move_l  (p2_l),
    .p2_move_r  (p2_r),
    .p2_attack  (p2_a),
    .p2_defense (p2_d),
    .start_key  (start_key),
    .game_over  (game_over),
    .phase      (phase),
    .round_reset(round_reset),
    .p1_action  (p1_action),
    .p2_action  (p2_action),
    .p1_anim    (p1_anim),
    .p2_anim    (p2_anim),
    .p1_strike  (p1_strike),
    .p2_strike  (p2_strike)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each player is "which action, how many ticks in it".
  typedef struct {
    int act;
    int cnt;
    bit prev;
    bit strike;
  } pm_t;

  pm_t m[2];
  int  m_ph = 0;
  bit  m_rr = 0;
  bit  m_sprev = 1;

  function automatic int pick(bit l, bit r, bit e, bit d);
    if (d) return 4;
    if (e) return 3;
    if (l && !r) return 1;
    if (r && !l) return 2;
    return 0;
  endfunction

  function automatic int m_anim(pm_t p);
    if (p.act == 1 || p.act == 2) return p.cnt % WALK;
    if (p.act == 3 || p.act == 5) return p.cnt;
    return 0;
  endfunction

  task automatic pstep(inout pm_t p, input bit frc, input bit tk,
                       input bit l, input bit r, input bit a, input bit d);
    bit e;
    int n;
    e = a && !p.prev;
    p.strike = 0;
    if (frc) begin
      p.act = 0;
      p.cnt = 0;
    end else if (tk) begin
      if (p.act == 3) begin
        if (p.cnt == ATK - 1) begin
          p.act = 5;
          p.cnt = 0;
        end else begin
          p.cnt++;
          p.strike = (p.cnt == HIT);
        end
      end else if (p.act == 5) begin
        if (p.cnt == COOL - 1) begin
          p.act = pick(l, r, e, d);
          p.cnt = 0;
        end else begin
          p.cnt++;
        end
      end else begin
        n = pick(l, r, e, d);
        if (n != p.act) begin
          p.act = n;
          p.cnt = 0;
        end else begin
          p.cnt++;
        end
      end
    end
    if (tk) p.prev = a;
  endtask

  task automatic model_step();
    bit frc, sedge;
    int nph;
    if (!Reset_n) begin
      m_ph = 0;
      m_rr = 0;
      m_sprev = 1;
      for (int k = 0; k < 2; k++) m[k] = '{0, 0, 1'b1, 1'b0};
    end else begin
      frc = (m_ph != 1) || m_rr;
      sedge = start_key && !m_sprev;
      nph = m_ph;
      if (m_ph == 0 && sedge) nph = 1;
      else if (m_ph == 1 && game_over) nph = 2;
      else if (m_ph == 2 && sedge) nph = 1;
      pstep(m[0], frc, frame_tick, p1_l, p1_r, p1_a, p1_d);
      pstep(m[1], frc, frame_tick, p2_l, p2_r, p2_a, p2_d);
      m_rr = (nph == 1) && (m_ph != 1);
      m_ph = nph;
      m_sprev = start_key;
    end
  endtask

  task automatic check_model();
    chk("model phase", 32'(phase), m_ph);
    chk("model round_reset", 32'(round_reset), int'(m_rr));
    chk("model p1_action", 32'(p1_action), m[0].act);
    chk("model p1_anim", 32'(p1_anim), m_anim(m[0]));
    chk("model p1_strike", 32'(p1_strike), int'(m[0].strike));
    chk("model p2_action", 32'(p2_action), m[1].act);
    chk("model p2_anim", 32'(p2_anim), m_anim(m[1]));
    chk("model p2_strike", 32'(p2_strike), int'(m[1].strike));
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    frame_tick = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic clear_keys();
    {p1_l, p1_r, p1_a, p1_d} = 4'b0;
    {p2_l, p2_r, p2_a, p2_d} = 4'b0;
    game_over = 1'b0;
  endtask

  task automatic to_play();
    Reset_n = 1'b0;
    clear_keys();
    start_key = 1'b0;
    frame_tick = 1'b0;
    cyc();
    cyc();
    Reset_n = 1'b1;
    cyc();
    start_key = 1'b1;
    cyc();
    start_key = 1'b0;
    cyc();
    tick();
    idle(1);
  endtask

  typedef struct {
    int rst, st, tk, a1;
    int ph, rr, act, anim;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // reset, held start, start edge, round_reset swallowing a press, reset mid-attack
    tbl[0]  = '{0, 1, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0,  0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0,  0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 0,  0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0,  0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0,  1, 1, 0, 0};
    tbl[6]  = '{1, 1, 1, 1,  1, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 1,  1, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 0,  1, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 1,  1, 0, 3, 0};
    tbl[10] = '{1, 0, 0, 1,  1, 0, 3, 0};
    tbl[11] = '{1, 0, 1, 1,  1, 0, 3, 1};
    tbl[12] = '{0, 0, 1, 1,  0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0,  0, 0, 0, 0};

    clear_keys();
    Reset_n = 1'b0;
    start_key = 1'b1;
    frame_tick = 1'b0;
    for (int i = 0; i < 14; i++) begin
      Reset_n = 1'(tbl[i].rst);
      start_key = 1'(tbl[i].st);
      frame_tick = 1'(tbl[i].tk);
      p1_a = 1'(tbl[i].a1);
      cyc();
      chk($sformatf("tbl%0d phase", i), 32'(phase), tbl[i].ph);
      chk($sformatf("tbl%0d rr", i), 32'(round_reset), tbl[i].rr);
      chk($sformatf("tbl%0d act", i), 32'(p1_action), tbl[i].act);
      chk($sformatf("tbl%0d anim", i), 32'(p1_anim), tbl[i].anim);
    end

    // held attack: 6 ATTACK, 4 COOLDOWN, then IDLE until re-press
    to_play();
    p1_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold act", 32'(p1_action), i < 6 ? 3 : (i < 10 ? 5 : 0));
      chk("hold anim", 32'(p1_anim), i < 6 ? i : (i < 10 ? i - 6 : 0));
      chk("hold strike", 32'(p1_strike), int'(i == 3));
      idle(2);
      chk("hold strike gone", 32'(p1_strike), 0);
    end
    p1_a = 1'b0;
    tick();
    chk("release act", 32'(p1_action), 0);
    p1_a = 1'b1;
    tick();
    chk("repress act", 32'(p1_action), 3);
    idle(2);

    // walk wrap, then both moves cancel
    to_play();
    p2_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("walk act", 32'(p2_action), 1);
      chk("walk anim", 32'(p2_anim), i % 8);
      idle(1);
    end
    p2_r = 1'b1;
    tick();
    chk("both move act", 32'(p2_action), 0);
    chk("both move anim", 32'(p2_anim), 0);

    // defense wins over attack; defense during attack is ignored
    to_play();
    p1_d = 1'b1;
    p1_a = 1'b1;
    tick();
    chk("def act", 32'(p1_action), 4);
    chk("def strike", 32'(p1_strike), 0);
    idle(1);
    {p1_d, p1_a} = 2'b00;
    tick();
    chk("def release", 32'(p1_action), 0);
    p1_a = 1'b1;
    tick();
    chk("atk start", 32'(p1_action), 3);
    p1_d = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("atk def act", 32'(p1_action), 3);
      chk("atk def anim", 32'(p1_anim), i);
      chk("atk def strike", 32'(p1_strike), int'(i == 3));
    end
    tick();
    chk("cool under def", 32'(p1_action), 5);
    repeat (4) tick();
    chk("cool exit def", 32'(p1_action), 4);

    // simultaneous strikes
    to_play();
    p1_a = 1'b1;
    p2_a = 1'b1;
    repeat (4) begin
      tick();
      idle(1);
    end
    to_play();
    p1_a = 1'b1;
    p2_a = 1'b1;
    repeat (4) tick();
    chk("dual p1 strike", 32'(p1_strike), 1);
    chk("dual p2 strike", 32'(p2_strike), 1);
    idle(1);
    chk("dual p1 off", 32'(p1_strike), 0);
    chk("dual p2 off", 32'(p2_strike), 0);

    // game over mid-attack, then restart
    to_play();
    p1_a = 1'b1;
    repeat (3) tick();
    chk("go anim", 32'(p1_anim), 2);
    game_over = 1'b1;
    cyc();
    chk("go phase", 32'(phase), 2);
    cyc();
    chk("go act", 32'(p1_action), 0);
    chk("go anim0", 32'(p1_anim), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("over act", 32'(p1_action), 0);
      chk("over strike", 32'(p1_strike), 0);
    end
    game_over = 1'b0;
    start_key = 1'b1;
    cyc();
    chk("restart phase", 32'(phase), 1);
    chk("restart rr", 32'(round_reset), 1);
    chk("restart p1 act", 32'(p1_action), 0);
    chk("restart p2 anim", 32'(p2_anim), 0);
    start_key = 1'b0;
    cyc();
    chk("restart rr off", 32'(round_reset), 0);

    // random traffic against the model
    to_play();
    for (int i = 0; i < 4000; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) p1_l = ~p1_l;
      if ($urandom_range(0, 5) == 0) p1_r = ~p1_r;
      if ($urandom_range(0, 4) == 0) p1_a = ~p1_a;
      if ($urandom_range(0, 7) == 0) p1_d = ~p1_d;
      if ($urandom_range(0, 5) == 0) p2_l = ~p2_l;
      if ($urandom_range(0, 5) == 0) p2_r = ~p2_r;
      if ($urandom_range(0, 4) == 0) p2_a = ~p2_a;
      if ($urandom_range(0, 7) == 0) p2_d = ~p2_d;
      if ($urandom_range(0, 19) == 0) start_key = ~start_key;
      if ($urandom_range(0, 79) == 0) game_over = ~game_over;
      Reset_n = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
